// File: rtl/mvprod_out_buffer_if.sv
// rtl/mvprod_out_buffer_if.sv - write-strobe and chunk-read bundle between two chained MVProd layers
interface mvprod_out_buffer_if #(
    parameter int WorkingRegs = 4
);
    logic                     wr_en;
    logic [7:0]               wr_data;
    logic                     wr_last;
    logic [WorkingRegs*8-1:0] out_data;
    logic                     out_data_ready;
    logic                     rd_chunk_in;
    logic                     rd_ptr_rst;
    logic                     rd_release;
    logic                     overflow;
    logic                     len_err;

    modport master (
        output wr_en, wr_data, wr_last, rd_chunk_in, rd_ptr_rst, rd_release,
        input  out_data, out_data_ready, overflow, len_err
    );

    modport slave (
        input  wr_en, wr_data, wr_last, rd_chunk_in, rd_ptr_rst, rd_release,
        output out_data, out_data_ready, overflow, len_err
    );
endinterface

// File: rtl/mvprod_out_buffer.sv
// rtl/mvprod_out_buffer.sv - ping-pong vector buffer packing serial results into chunks for the next layer
// Optional MVPROD_OUT_BUFFER_RELU_EN: clamp negative elements to zero on write.
module mvprod_out_buffer #(
    parameter int VecLength   = 16,
    parameter int WorkingRegs = 4
) (
    input logic                clk_in,
    input logic                rst_in,
    mvprod_out_buffer_if.slave bus
);
    localparam int NCH = VecLength / WorkingRegs;
    localparam int IW  = (VecLength > 1) ? $clog2(VecLength) : 1;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LW  = (WorkingRegs > 1) ? $clog2(WorkingRegs) : 1;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} bank_state_t;

    bank_state_t                       state_q [2];
    logic [WorkingRegs-1:0][7:0]       mem_q   [2][NCH];
    logic                              wr_bank_q;
    logic                              rd_bank_q;
    logic [IW-1:0]                     wr_idx_q;
    logic [CW-1:0]                     rd_ptr_q;
    logic [WorkingRegs-1:0][7:0]       out_data_q;
    logic                              ready_q;
    logic                              overflow_q;
    logic                              len_err_q;
    logic                              over_q;

    bank_state_t   eff [2];
    logic          release_ok;
    logic          tgt_ok;
    logic          tgt_bank;
    logic          tgt_other;
    logic          wr_other;
    logic          do_write;
    logic          complete;
    logic [7:0]    wr_val;
    logic [CW-1:0] wr_chunk;
    logic [LW-1:0] wr_lane;
    logic [CW-1:0] rd_ptr_d;
    logic          rd_bank_d;
    logic          ready_d;

    function automatic logic avail(input bank_state_t s);
        return (s == FULL) || (s == READING);
    endfunction

    function automatic logic writable(input bank_state_t s);
        return (s == EMPTY) || (s == FILLING);
    endfunction

    always_comb begin
        release_ok = bus.rd_release && ready_q;
        wr_other   = ~wr_bank_q;
        // The release is folded in first so a completing write can hop straight into the freed bank.
        eff[0] = state_q[0];
        eff[1] = state_q[1];
        if (release_ok) eff[rd_bank_q] = EMPTY;

        tgt_ok   = 1'b0;
        tgt_bank = wr_bank_q;
        if (writable(eff[wr_bank_q])) begin
            tgt_ok = 1'b1;
        end else if (eff[wr_other] == EMPTY) begin
            tgt_ok   = 1'b1;
            tgt_bank = wr_other;
        end
        tgt_other = ~tgt_bank;

        do_write = bus.wr_en && !over_q && tgt_ok;
        complete = do_write && (bus.wr_last || wr_idx_q == IW'(VecLength - 1));
        wr_chunk = CW'(32'(wr_idx_q) / WorkingRegs);
        wr_lane  = LW'(32'(wr_idx_q) % WorkingRegs);

        wr_val = bus.wr_data;
`ifdef MVPROD_OUT_BUFFER_RELU_EN
        if (bus.wr_data[7]) wr_val = 8'h00;
`endif

        rd_bank_d = release_ok ? ~rd_bank_q : rd_bank_q;
        if (release_ok || bus.rd_ptr_rst) begin
            rd_ptr_d = '0;
        end else if (bus.rd_chunk_in) begin
            rd_ptr_d = (rd_ptr_q == CW'(NCH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        // Rising edge of ready lags the FULL status by a cycle; a release takes effect at once.
        ready_d = release_ok ? avail(state_q[~rd_bank_q]) : avail(state_q[rd_bank_q]);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q[0] <= EMPTY;
            state_q[1] <= EMPTY;
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < NCH; c++) begin
                    mem_q[b][c] <= '0;
                end
            end
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_idx_q   <= '0;
            rd_ptr_q   <= '0;
            out_data_q <= '0;
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
            len_err_q  <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q[0] <= eff[0];
            state_q[1] <= eff[1];
            if (!release_ok && state_q[rd_bank_q] == FULL && (bus.rd_chunk_in || bus.rd_ptr_rst))
                state_q[rd_bank_q] <= READING;

            if (do_write) begin
                // Clearing the bank on the first element makes short vectors read back zero-padded.
                if (wr_idx_q == '0) begin
                    for (int c = 0; c < NCH; c++) mem_q[tgt_bank][c] <= '0;
                end
                mem_q[tgt_bank][wr_chunk][wr_lane] <= wr_val;
                state_q[tgt_bank] <= complete ? FULL : FILLING;
                wr_idx_q          <= complete ? '0 : wr_idx_q + 1'b1;
            end

            if (complete) begin
                wr_bank_q <= (eff[tgt_other] == EMPTY) ? tgt_other : tgt_bank;
            end else if (do_write) begin
                wr_bank_q <= tgt_bank;
            end else if (!writable(eff[wr_bank_q]) && eff[wr_other] == EMPTY) begin
                wr_bank_q <= wr_other;
            end

            // over_q swallows the tail of an over-long vector up to and including its wr_last.
            if (bus.wr_en && over_q) begin
                len_err_q <= 1'b1;
                if (bus.wr_last) over_q <= 1'b0;
            end else if (complete && !bus.wr_last) begin
                over_q <= 1'b1;
            end else if (complete && wr_idx_q != IW'(VecLength - 1)) begin
                len_err_q <= 1'b1;
            end else if (bus.wr_en && !tgt_ok) begin
                overflow_q <= 1'b1;
            end

            rd_bank_q  <= rd_bank_d;
            rd_ptr_q   <= rd_ptr_d;
            ready_q    <= ready_d;
            out_data_q <= mem_q[rd_bank_d][rd_ptr_d];
        end
    end

    assign bus.out_data       = out_data_q;
    assign bus.out_data_ready = ready_q;
    assign bus.overflow       = overflow_q;
    assign bus.len_err        = len_err_q;
endmodule

// File: tb/tb_mvprod_out_buffer.sv
// tb/tb_mvprod_out_buffer.sv - scoreboard bench for mvprod_out_buffer against a vector-level model
`timescale 1ns/1ps
module tb_mvprod_out_buffer;
    localparam int VL  = 16;
    localparam int WR  = 4;
    localparam int NCH = VL / WR;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } el_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mvprod_out_buffer_if #(.WorkingRegs(WR)) bus ();

    mvprod_out_buffer #(.VecLength(VL), .WorkingRegs(WR)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    el_t                stream [$];
    logic [VL*8-1:0]    mdl_q  [$];
    logic [WR*8-1:0]    exp_q  [$];
    int                 p = 0;
    logic               exp_ovf = 1'b0;
    logic               exp_len = 1'b0;

    function automatic logic [7:0] relu(input logic [7:0] x);
`ifdef MVPROD_OUT_BUFFER_RELU_EN
        return x[7] ? 8'h00 : x;
`else
        return x;
`endif
    endfunction

    function automatic logic [WR*8-1:0] chunk_of(input logic [VL*8-1:0] v, input int c);
        return v[c*WR*8 +: WR*8];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [WR*8-1:0] e;
            e = exp_q.pop_front();
            checks++;
            if (!(bus.out_data_ready === 1'b1 && bus.out_data === e)) begin
                errors++;
                $display("FAIL chunk: got %h ready=%b expected %h", bus.out_data, bus.out_data_ready, e);
            end
        end
    end

    // mode 0: values 1..n; mode 2: element 0 is -5, rest random; otherwise random
    task automatic add_vec(input int n, input int mode);
        logic [VL*8-1:0] v;
        logic [7:0]      e;
        el_t             s;
        bit              keep;
        keep = (mdl_q.size() < 2);
        v    = '0;
        for (int i = 0; i < n; i++) begin
            if (mode == 0)                e = 8'(i + 1);
            else if (mode == 2 && i == 0) e = 8'hFB;
            else                          e = 8'($urandom);
            s.d = e;
            s.l = (i == n - 1);
            stream.push_back(s);
            if (keep && i < VL) v[i*8 +: 8] = relu(e);
        end
        if (keep) begin
            mdl_q.push_back(v);
            if (n != VL) exp_len = 1'b1;
        end else begin
            exp_ovf = 1'b1;
        end
    endtask

    task automatic drive_stream();
        el_t s;
        while (stream.size() > 0) begin
            s = stream.pop_front();
            bus.wr_en   = 1'b1;
            bus.wr_data = s.d;
            bus.wr_last = s.l;
            @(posedge clk); #1;
        end
        bus.wr_en   = 1'b0;
        bus.wr_last = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (bus.out_data_ready !== 1'b1 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, 32'(bus.out_data_ready), 32'd1);
    endtask

    task automatic present();
        if (mdl_q.size() > 0) exp_q.push_back(chunk_of(mdl_q[0], p));
    endtask

    // mode 0: steady advances; mode 1: chunks 0..2 then rewind with advance, then random; else random
    task automatic read_ops(input int n, input int mode);
        int op;
        present();
        for (int i = 0; i < n; i++) begin
            if (mode == 0)                op = 1;
            else if (mode == 1 && i < 2)  op = 1;
            else if (mode == 1 && i == 2) op = 3;
            else                          op = int'($urandom_range(0, 3));
            bus.rd_chunk_in = op[0];
            bus.rd_ptr_rst  = op[1];
            @(posedge clk); #1;
            if (op[1])      p = 0;
            else if (op[0]) p = (p + 1) % NCH;
            present();
        end
        bus.rd_chunk_in = 1'b0;
        bus.rd_ptr_rst  = 1'b0;
    endtask

    task automatic release_head();
        bus.rd_release = 1'b1;
        @(posedge clk); #1;
        bus.rd_release = 1'b0;
        mdl_q.delete(0);
        p = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        el_t s;
        bus.wr_en = 1'b0; bus.wr_data = '0; bus.wr_last = 1'b0;
        bus.rd_chunk_in = 1'b0; bus.rd_ptr_rst = 1'b0; bus.rd_release = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset_ready", 32'(bus.out_data_ready), 32'd0);
        chk("reset_overflow", 32'(bus.overflow), 32'd0);
        chk("reset_len_err", 32'(bus.len_err), 32'd0);
        chk("reset_out_data", bus.out_data, 32'd0);

        // values 1..16: ready one cycle after the completing edge, then wrap read
        add_vec(VL, 0);
        drive_stream();
        chk("ready_lag", 32'(bus.out_data_ready), 32'd0);
        @(posedge clk); #1;
        chk("ready_up", 32'(bus.out_data_ready), 32'd1);
        read_ops(4, 0);
        release_head();
        @(posedge clk); #1;
        chk("ready_after_release", 32'(bus.out_data_ready), 32'd0);

        // rewind wins over advance
        add_vec(VL, 1);
        drive_stream();
        wait_ready("ready_rewind_vec");
        read_ops(12, 1);
        release_head();
        chk("len_err_clean", 32'(bus.len_err), 32'(exp_len));

        // over-long vector: the 17th element is dropped
        add_vec(VL + 1, 1);
        drive_stream();
        wait_ready("ready_overlong");
        chk("len_err_overlong", 32'(bus.len_err), 32'(exp_len));
        read_ops(6, 3);
        release_head();

        // short vector padded with zeros
        add_vec(6, 0);
        drive_stream();
        wait_ready("ready_short");
        read_ops(4, 0);
        release_head();

        add_vec(VL, 2);
        drive_stream();
        wait_ready("ready_neg");
`ifdef MVPROD_OUT_BUFFER_RELU_EN
        chk("neg_lane0", 32'(bus.out_data[7:0]), 32'h00);
`else
        chk("neg_lane0", 32'(bus.out_data[7:0]), 32'hFB);
`endif
        read_ops(5, 3);
        release_head();
        chk("overflow_clean", 32'(bus.overflow), 32'(exp_ovf));

        // A, B, C back to back: C is dropped
        add_vec(VL, 1);
        add_vec(VL, 1);
        add_vec(VL, 1);
        drive_stream();
        wait_ready("ready_abc");
        chk("overflow_set", 32'(bus.overflow), 32'(exp_ovf));
        read_ops(8, 3);
        release_head();
        chk("ready_hold_0", 32'(bus.out_data_ready), 32'd1);
        @(posedge clk); #1;
        chk("ready_hold_1", 32'(bus.out_data_ready), 32'd1);
        read_ops(8, 3);
        release_head();

        // reset during a partial write with a full vector pending
        add_vec(VL, 1);
        drive_stream();
        wait_ready("ready_pre_reset");
        for (int i = 0; i < 3; i++) begin
            s.d = 8'(i + 100);
            s.l = 1'b0;
            stream.push_back(s);
        end
        drive_stream();
        #2 rst = 1'b1;
        #1;
        chk("async_ready", 32'(bus.out_data_ready), 32'd0);
        chk("async_overflow", 32'(bus.overflow), 32'd0);
        chk("async_len_err", 32'(bus.len_err), 32'd0);
        mdl_q.delete();
        p = 0;
        exp_ovf = 1'b0;
        exp_len = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        add_vec(VL, 1);
        drive_stream();
        wait_ready("ready_post_reset");
        read_ops(6, 3);
        release_head();
        chk("post_reset_flags", {30'd0, bus.overflow, bus.len_err}, {30'd0, exp_ovf, exp_len});

        @(posedge clk); #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
